// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner
//   Row-scan driver for N_PANELS side-by-side LED dot-matrix panels sharing row
//   lines. Holds a two-page host-writable frame buffer and presents one row per
//   scan tick, with static, page-blink, blank-blink and marquee-scroll modes.
//   Blink and scroll timing come from a divider on the scan clock.
// Ports
//   clk_10000Hz  scan clock
//   reset        asynchronous active-low reset
//   wr_en        write one buffer row this cycle
//   wr_page      target page (0/1)
//   wr_panel     target panel (0 = leftmost)
//   wr_row       target row (0 = top)
//   wr_data      row pixels, MSB = leftmost, 1 = lit
//   mode         00 static p0, 01 blink p0/p1, 10 blink p0/blank, 11 scroll p0
//   dot_row      active-low one-hot row select, row 0 drives the MSB low
//   dot_col      column drive, [W-1 -: COLS] = panel 0, 1 = lit
//   frame_start  one-cycle pulse on the cycle row 0 is loaded
//   blink_phase  0 = first half-period (page 0 shown)
module dot_matrix_scanner #(
  parameter int N_PANELS  = 2,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 5000
) (
  input  logic                          clk_10000Hz,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic                          wr_page,
  input  logic [$clog2(N_PANELS)-1:0]   wr_panel,
  input  logic [$clog2(ROWS)-1:0]       wr_row,
  input  logic [COLS-1:0]               wr_data,
  input  logic [1:0]                    mode,
  output logic [ROWS-1:0]               dot_row,
  output logic [N_PANELS*COLS-1:0]      dot_col,
  output logic                          frame_start,
  output logic                          blink_phase
);

  localparam int W  = N_PANELS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(N_PANELS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam int OW = (W > 1) ? $clog2(W) : 1;
  localparam logic [ROWS-1:0] ROW0_BIT = {1'b1, {(ROWS-1){1'b0}}};

  logic [W-1:0]    page0 [ROWS];
  logic [W-1:0]    page1 [ROWS];
  logic [SW-1:0]   scan_cnt;
  logic [RW-1:0]   row_idx;
  logic [BW-1:0]   blink_cnt;
  logic [OW-1:0]   offset;
  logic [1:0]      mode_q;
  logic            tick;
  logic            blink_wrap;
  logic            mode_chg;
  logic [W-1:0]    row_p0;
  logic [W-1:0]    row_p1;
  logic [W-1:0]    col_next;
  logic [2*W-1:0]  rot_dbl;
  logic [ROWS-1:0] row_sel;

  assign tick       = (scan_cnt == SW'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
  assign mode_chg   = (mode != mode_q);
  assign row_p0     = page0[row_idx];
  assign row_p1     = page1[row_idx];
  assign row_sel    = ~(ROW0_BIT >> row_idx);

  // Column source for the row being loaded. Reads the buffer before any write
  // landing on the same edge, so a same-row write shows up on the next scan.
  always_comb begin
    rot_dbl = {row_p0, row_p0} << offset;
    case (mode_q)
      2'b00:   col_next = row_p0;
      2'b01:   col_next = blink_phase ? row_p1 : row_p0;
      2'b10:   col_next = blink_phase ? '0 : row_p0;
      default: col_next = rot_dbl[2*W-1 -: W];  // rotate left by offset
    endcase
  end

  // Frame buffer, both pages cleared on reset; out-of-range addresses match no slot.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        page0[r] <= '0;
        page1[r] <= '0;
      end
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int p = 0; p < N_PANELS; p++) begin
          if (wr_row == RW'(r) && wr_panel == PW'(p)) begin
            if (wr_page) page1[r][W-1-p*COLS -: COLS] <= wr_data;
            else         page0[r][W-1-p*COLS -: COLS] <= wr_data;
          end
        end
      end
    end
  end

  // Row scan and output registers.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      scan_cnt    <= '0;
      row_idx     <= '0;
      dot_row     <= '1;
      dot_col     <= '0;
      frame_start <= 1'b0;
    end else begin
      scan_cnt    <= tick ? '0 : scan_cnt + 1'b1;
      frame_start <= 1'b0;
      if (tick) begin
        dot_row     <= row_sel;
        dot_col     <= col_next;
        frame_start <= (row_idx == '0);
        row_idx     <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end
    end
  end

  // Blink / scroll timer; a mode change restarts it without touching the scan.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      offset      <= '0;
      mode_q      <= 2'b00;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        offset      <= '0;
      end else if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
        if (mode_q == 2'b11)
          offset <= (offset == OW'(W - 1)) ? '0 : offset + 1'b1;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Testbench for dot_matrix_scanner: main 2x8x8 instance with a fast blink
// divider, plus a 6-row instance whose 3-bit row address can point past the
// last row.
module tb_dot_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_page = 1'b0;
  logic        wr_panel = 1'b0;
  logic [2:0]  wr_row = 3'd0;
  logic [7:0]  wr_data = 8'h00;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  dot_row;
  logic [15:0] dot_col;
  logic        frame_start;
  logic        blink_phase;

  logic        s_wr_en = 1'b0;
  logic        s_wr_page = 1'b0;
  logic        s_wr_panel = 1'b0;
  logic [2:0]  s_wr_row = 3'd0;
  logic [7:0]  s_wr_data = 8'h00;
  logic [1:0]  s_mode = 2'b00;
  logic [5:0]  s_dot_row;
  logic [15:0] s_dot_col;
  logic        s_frame_start;
  logic        s_blink_phase;

  int n_cmp = 0;
  int n_err = 0;
  int ecount = 0;

  logic [15:0] exp_col_q[$];
  logic [7:0]  exp_row_q[$];
  logic        exp_fs_q[$];

  logic [7:0] glyph [8] = '{8'h3C, 8'h42, 8'h81, 8'h81, 8'h81, 8'h81, 8'h42, 8'h3C};

  always #5 clk = ~clk;

  // Edges since reset release; edge n loads row (n-1) mod ROWS.
  always @(posedge clk) begin
    if (!reset) ecount = 0;
    else        ecount = ecount + 1;
  end

  dot_matrix_scanner #(.N_PANELS(2), .ROWS(8), .COLS(8), .SCAN_DIV(1), .BLINK_DIV(4)) u_dut (
    .clk_10000Hz(clk), .reset(reset), .wr_en(wr_en), .wr_page(wr_page),
    .wr_panel(wr_panel), .wr_row(wr_row), .wr_data(wr_data), .mode(mode),
    .dot_row(dot_row), .dot_col(dot_col), .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  dot_matrix_scanner #(.N_PANELS(2), .ROWS(6), .COLS(8), .SCAN_DIV(1), .BLINK_DIV(4)) u_small (
    .clk_10000Hz(clk), .reset(reset), .wr_en(s_wr_en), .wr_page(s_wr_page),
    .wr_panel(s_wr_panel), .wr_row(s_wr_row), .wr_data(s_wr_data), .mode(s_mode),
    .dot_row(s_dot_row), .dot_col(s_dot_col), .frame_start(s_frame_start),
    .blink_phase(s_blink_phase)
  );

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int s);
    int sh;
    sh = s % 16;
    if (sh == 0) return v;
    return (v << sh) | (v >> (16 - sh));
  endfunction

  function automatic logic [7:0] row_code(input int r);
    logic [7:0] v;
    v = 8'h80 >> r;
    return ~v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic pg, input logic pn, input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_page = pg; wr_panel = pn; wr_row = r; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] er; logic [15:0] ec; logic ef;
    reset = 1'b0; mode = 2'b00;
    step(); step();
    n_cmp++; if (dot_row !== 8'hFF) begin n_err++; $display("FAIL reset_row got %h exp FF", dot_row); end
    n_cmp++; if (dot_col !== 16'h0) begin n_err++; $display("FAIL reset_col got %h exp 0000", dot_col); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b exp 0", frame_start); end
    n_cmp++; if (blink_phase !== 1'b0) begin n_err++; $display("FAIL reset_phase got %b exp 0", blink_phase); end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_row_q.push_back(row_code(k % 8));
      exp_fs_q.push_back(k % 8 == 0);
      exp_col_q.push_back(16'h0000);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      er = exp_row_q.pop_front(); ef = exp_fs_q.pop_front(); ec = exp_col_q.pop_front();
      n_cmp++; if (dot_row !== er) begin n_err++; $display("FAIL scan_row k=%0d got %h exp %h", k, dot_row, er); end
      n_cmp++; if (frame_start !== ef) begin n_err++; $display("FAIL scan_fs k=%0d got %b exp %b", k, frame_start, ef); end
      n_cmp++; if (dot_col !== ec) begin n_err++; $display("FAIL scan_col k=%0d got %h exp %h", k, dot_col, ec); end
    end
  endtask

  task automatic test_static();
    int t;
    logic [7:0] er; logic [15:0] ec;
    for (int r = 0; r < 8; r++) begin
      do_write(1'b0, 1'b0, 3'(r), glyph[r]);
      do_write(1'b0, 1'b1, 3'(r), 8'h00);
    end
    for (int r = 0; r < 8; r++) begin
      exp_row_q.push_back(row_code(r));
      exp_col_q.push_back({glyph[r], 8'h00});
    end
    t = 0;
    while (frame_start !== 1'b1 && t < 20) begin step(); t++; end
    n_cmp++;
    if (frame_start !== 1'b1) begin n_err++; $display("FAIL static_wait got no frame_start exp pulse"); end
    for (int r = 0; r < 8; r++) begin
      if (r > 0) step();
      er = exp_row_q.pop_front(); ec = exp_col_q.pop_front();
      n_cmp++; if (dot_row !== er) begin n_err++; $display("FAIL static_row r=%0d got %h exp %h", r, dot_row, er); end
      n_cmp++; if (dot_col !== ec) begin n_err++; $display("FAIL static_col r=%0d got %h exp %h", r, dot_col, ec); end
    end
  endtask

  task automatic test_blink();
    logic       ep;
    logic [15:0] ec;
    int n_pg0, n_pg1;
    n_pg0 = 0; n_pg1 = 0;
    do_write(1'b1, 1'b1, 3'd0, 8'h81);
    for (int p = 0; p < 2; p++) begin
      mode = 2'b00;
      repeat (p == 0 ? 1 : 5) step();
      mode = 2'b01;
      for (int k = 1; k <= 24; k++) begin
        step();
        ep = 1'(((k - 1) / 4) % 2);
        n_cmp++;
        if (blink_phase !== ep) begin n_err++; $display("FAIL blink_phase p=%0d k=%0d got %b exp %b", p, k, blink_phase, ep); end
        if (k >= 2 && (ecount - 1) % 8 == 0) begin
          exp_col_q.push_back((((k - 2) / 4) % 2 == 1) ? 16'h0081 : 16'h3C00);
          ec = exp_col_q.pop_front();
          if (ec == 16'h0081) n_pg1++; else n_pg0++;
          n_cmp++;
          if (dot_col !== ec) begin n_err++; $display("FAIL blink_col p=%0d k=%0d got %h exp %h", p, k, dot_col, ec); end
        end
      end
    end
    n_cmp++;
    if (n_pg0 == 0 || n_pg1 == 0) begin n_err++; $display("FAIL blink_alt got pg0=%0d pg1=%0d exp both nonzero", n_pg0, n_pg1); end
  endtask

  task automatic test_scroll();
    logic [15:0] ec;
    do_write(1'b0, 1'b0, 3'd0, 8'h80);
    do_write(1'b0, 1'b1, 3'd0, 8'h00);
    mode = 2'b11;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k >= 2 && (ecount - 1) % 8 == 0) begin
        exp_col_q.push_back(rotl16(16'h8000, (k - 2) / 4));
        ec = exp_col_q.pop_front();
        n_cmp++;
        if (dot_col !== ec) begin n_err++; $display("FAIL scroll_col k=%0d got %h exp %h", k, dot_col, ec); end
      end
    end
  endtask

  task automatic test_rbw();
    int t;
    logic [15:0] ec;
    mode = 2'b00;
    repeat (3) step();
    exp_col_q.push_back({8'h81, 8'h00});
    exp_col_q.push_back({8'hFF, 8'h00});
    t = 0;
    while (ecount % 8 != 3 && t < 10) begin step(); t++; end
    do_write(1'b0, 1'b0, 3'd3, 8'hFF);
    ec = exp_col_q.pop_front();
    n_cmp++; if (dot_row !== 8'hEF) begin n_err++; $display("FAIL rbw_row got %h exp EF", dot_row); end
    n_cmp++; if (dot_col !== ec) begin n_err++; $display("FAIL rbw_old got %h exp %h", dot_col, ec); end
    repeat (8) step();
    ec = exp_col_q.pop_front();
    n_cmp++; if (dot_row !== 8'hEF) begin n_err++; $display("FAIL rbw_row2 got %h exp EF", dot_row); end
    n_cmp++; if (dot_col !== ec) begin n_err++; $display("FAIL rbw_new got %h exp %h", dot_col, ec); end
  endtask

  task automatic test_out_of_range();
    logic [5:0] er; logic [15:0] ec; int r;
    s_wr_en = 1'b1; s_wr_page = 1'b0;
    s_wr_panel = 1'b0; s_wr_row = 3'd6; s_wr_data = 8'hFF; step();
    s_wr_panel = 1'b1; s_wr_row = 3'd7; s_wr_data = 8'hFF; step();
    s_wr_panel = 1'b1; s_wr_row = 3'd5; s_wr_data = 8'hA5; step();
    s_wr_en = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 12; k++) begin
      step();
      r = (ecount - 1) % 6;
      er = ~(6'h20 >> r);
      ec = (r == 5) ? 16'h00A5 : 16'h0000;
      n_cmp++; if (s_dot_row !== er) begin n_err++; $display("FAIL oor_row r=%0d got %h exp %h", r, s_dot_row, er); end
      n_cmp++; if (s_dot_col !== ec) begin n_err++; $display("FAIL oor_col r=%0d got %h exp %h", r, s_dot_col, ec); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    t = 0;
    while (dot_row !== 8'hEF && t < 16) begin step(); t++; end
    n_cmp++;
    if (dot_row !== 8'hEF) begin n_err++; $display("FAIL mid_wait got %h exp EF", dot_row); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dot_row !== 8'hFF) begin n_err++; $display("FAIL mid_row got %h exp FF", dot_row); end
    n_cmp++; if (dot_col !== 16'h0) begin n_err++; $display("FAIL mid_col got %h exp 0000", dot_col); end
    n_cmp++; if (s_dot_row !== 6'h3F) begin n_err++; $display("FAIL mid_srow got %h exp 3F", s_dot_row); end
    step();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++; if (dot_row !== row_code(k)) begin n_err++; $display("FAIL post_row k=%0d got %h exp %h", k, dot_row, row_code(k)); end
      n_cmp++; if (dot_col !== 16'h0) begin n_err++; $display("FAIL post_col k=%0d got %h exp 0000", k, dot_col); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_blink();
    test_scroll();
    test_rbw();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
